// File: rtl/microseq_pkg.sv
// rtl/microseq_pkg.sv - microsequencer op encodings, microword field layout helpers, clog2
package microseq_pkg;

  // Sequencing op encodings (microword op field, 4 bits)
  localparam logic [3:0] OP_DISPATCH = 4'd0;
  localparam logic [3:0] OP_FETCH    = 4'd1;
  localparam logic [3:0] OP_JUMP     = 4'd2;
  localparam logic [3:0] OP_NEXT     = 4'd3;
  localparam logic [3:0] OP_BRANCH   = 4'd4;
  localparam logic [3:0] OP_WAIT     = 4'd5;
  localparam logic [3:0] OP_CALL     = 4'd6;
  localparam logic [3:0] OP_RETURN   = 4'd7;
  localparam logic [3:0] OP_CCALL    = 4'd8;
  localparam logic [3:0] OP_CRETURN  = 4'd9;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Condition-select field is never narrower than one bit.
  function automatic int csel_w(input int ncond);
    return (clog2(ncond) < 1) ? 1 : clog2(ncond);
  endfunction

  // Microword layout, MSB->LSB: op[3:0], inv, csel, ctrl, target
  function automatic int word_w(input int addr_w, input int ctrl_w, input int ncond);
    return 5 + csel_w(ncond) + ctrl_w + addr_w;
  endfunction

  function automatic int ctrl_lo(input int addr_w);
    return addr_w;
  endfunction

  function automatic int csel_lo(input int addr_w, input int ctrl_w);
    return addr_w + ctrl_w;
  endfunction

  function automatic int inv_bit(input int addr_w, input int ctrl_w, input int ncond);
    return addr_w + ctrl_w + csel_w(ncond);
  endfunction

  function automatic int op_lo(input int addr_w, input int ctrl_w, input int ncond);
    return inv_bit(addr_w, ctrl_w, ncond) + 1;
  endfunction

endpackage

// File: rtl/microseq_lifo.sv
// rtl/microseq_lifo.sv - return-address LIFO, DEPTH x WIDTH
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset (clears count only)
//   push, pop        push_data onto / remove top entry (push ignored when full, pop when empty)
//   push_data        value to push
//   top              current top entry (0 when empty)
//   count            number of valid entries
//   full, empty      occupancy flags
module microseq_lifo
  import microseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Entry storage needs no reset: entries above count are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !full && (count == CNT_W'(i))) mem[i] <= push_data;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count == CNT_W'(i + 1)) top = mem[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/microseq_stack.sv
// rtl/microseq_stack.sv - microprogram sequencer with call/return stack and wait states
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   ustore_addr      microstore read address (combinational)
//   uword_in         microword read at ustore_addr, same cycle
//   dispatch_addr    decoder entry address for the current instruction
//   cond             status inputs (bit 0 = MOC, bit 1 = Cond)
//   ctrl             control lines from the control register
//   curr_state       address of the microword held in the control register
//   sp               return-stack occupancy
//   err              sticky overflow / underflow / illegal-op flag
module microseq_stack
  import microseq_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int CTRL_W      = 20,
  parameter int NCOND       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int FETCH_ADDR  = 1,
  localparam int CSEL_W = csel_w(NCOND),
  localparam int WORD_W = word_w(ADDR_W, CTRL_W, NCOND),
  localparam int SP_W   = clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] ustore_addr,
  input  logic [WORD_W-1:0] uword_in,
  input  logic [ADDR_W-1:0] dispatch_addr,
  input  logic [NCOND-1:0]  cond,
  output logic [CTRL_W-1:0] ctrl,
  output logic [ADDR_W-1:0] curr_state,
  output logic [SP_W-1:0]   sp,
  output logic              err
);

  localparam int CTRL_LO = ctrl_lo(ADDR_W);
  localparam int CSEL_LO = csel_lo(ADDR_W, CTRL_W);
  localparam int INV_BIT = inv_bit(ADDR_W, CTRL_W, NCOND);
  localparam int OP_LO   = op_lo(ADDR_W, CTRL_W, NCOND);
  localparam logic [ADDR_W-1:0] FETCH_A = ADDR_W'(FETCH_ADDR);

  logic [WORD_W-1:0] ureg;
  logic              boot;

  logic [3:0]        op;
  logic              inv;
  logic [CSEL_W-1:0] csel;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] inc;
  logic              cond_bit;
  logic              sts;

  logic [ADDR_W-1:0] nxt;
  logic              call_req;
  logic              ret_req;
  logic              do_push;
  logic              do_pop;
  logic              set_err;

  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;

  assign op     = ureg[OP_LO +: 4];
  assign inv    = ureg[INV_BIT];
  assign csel   = ureg[CSEL_LO +: CSEL_W];
  assign ctrl   = ureg[CTRL_LO +: CTRL_W];
  assign target = ureg[0 +: ADDR_W];
  assign inc    = curr_state + ADDR_W'(1);

  // Selects beyond the last status input read as 0.
  always_comb begin
    cond_bit = 1'b0;
    for (int i = 0; i < NCOND; i++) begin
      if (csel == CSEL_W'(i)) cond_bit = cond[i];
    end
  end

  assign sts = cond_bit ^ inv;

  always_comb begin
    nxt      = inc;
    call_req = 1'b0;
    ret_req  = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    set_err  = 1'b0;
    case (op)
      OP_DISPATCH: nxt = dispatch_addr;
      OP_FETCH:    nxt = FETCH_A;
      OP_JUMP:     nxt = target;
      OP_NEXT:     nxt = inc;
      OP_BRANCH:   nxt = sts ? target : inc;
      OP_WAIT:     nxt = sts ? inc : curr_state;
      OP_CALL:     call_req = 1'b1;
      OP_RETURN:   ret_req = 1'b1;
      OP_CCALL:    call_req = sts;
      OP_CRETURN:  ret_req = sts;
      default:     set_err = 1'b1;
    endcase

    // Overflow drops the return address but still takes the call.
    if (call_req) begin
      nxt = target;
      if (stk_full) set_err = 1'b1;
      else          do_push = 1'b1;
    end

    // Underflow restarts at the fetch entry.
    if (ret_req) begin
      if (stk_empty) begin
        nxt     = FETCH_A;
        set_err = 1'b1;
      end else begin
        nxt    = stk_top;
        do_pop = 1'b1;
      end
    end
  end

  assign ustore_addr = boot ? '0 : nxt;

  microseq_lifo #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push & ~boot),
    .pop       (do_pop & ~boot),
    .push_data (inc),
    .top       (stk_top),
    .count     (sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // boot marks the first cycle after reset release, when the control
  // register still holds the cleared word rather than a fetched one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boot       <= 1'b1;
      ureg       <= '0;
      curr_state <= '0;
      err        <= 1'b0;
    end else begin
      boot       <= 1'b0;
      ureg       <= uword_in;
      curr_state <= ustore_addr;
      err        <= err | (set_err & ~boot);
    end
  end

endmodule

// File: tb/tb_microseq_stack.sv
// tb/tb_microseq_stack.sv - directed self-checking bench for microseq_stack
module tb_microseq_stack;

  logic        clk;
  logic        reset;
  logic [6:0]  ustore_addr;
  logic [33:0] uword_in;
  logic [6:0]  dispatch_addr;
  logic [3:0]  cond;
  logic [19:0] ctrl;
  logic [6:0]  curr_state;
  logic [2:0]  sp;
  logic        err;

  logic [33:0] ustore [128];

  int total;
  int bad;

  microseq_stack #(
    .ADDR_W      (7),
    .CTRL_W      (20),
    .NCOND       (4),
    .STACK_DEPTH (4),
    .FETCH_ADDR  (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ustore_addr   (ustore_addr),
    .uword_in      (uword_in),
    .dispatch_addr (dispatch_addr),
    .cond          (cond),
    .ctrl          (ctrl),
    .curr_state    (curr_state),
    .sp            (sp),
    .err           (err)
  );

  assign uword_in = ustore[ustore_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl field of the word at address a: 0x12340 + 3*a
  function automatic logic [33:0] mk(input logic [3:0] op, input logic inv,
                                     input logic [1:0] csel, input logic [6:0] tgt,
                                     input logic [6:0] here);
    logic [19:0] c;
    c = 20'h12340 + {13'd0, here} * 20'd3;
    return {op, inv, csel, c, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    cond = 4'b0000;
    dispatch_addr = 7'd0;

    for (int i = 0; i < 128; i++) ustore[i] = mk(4'd2, 1'b0, 2'd0, 7'(i), 7'(i));
    ustore[0]   = mk(4'd2, 1'b0, 2'd0, 7'd5,   7'd0);
    ustore[1]   = mk(4'd2, 1'b0, 2'd0, 7'd1,   7'd1);
    ustore[5]   = mk(4'd2, 1'b0, 2'd0, 7'd8,   7'd5);
    ustore[8]   = mk(4'd5, 1'b0, 2'd0, 7'd0,   7'd8);
    ustore[9]   = mk(4'd2, 1'b0, 2'd0, 7'd10,  7'd9);
    ustore[10]  = mk(4'd4, 1'b1, 2'd1, 7'd40,  7'd10);
    ustore[40]  = mk(4'd2, 1'b0, 2'd0, 7'd10,  7'd40);
    ustore[11]  = mk(4'd2, 1'b0, 2'd0, 7'd20,  7'd11);
    ustore[20]  = mk(4'd6, 1'b0, 2'd0, 7'd50,  7'd20);
    ustore[50]  = mk(4'd7, 1'b0, 2'd0, 7'd0,   7'd50);
    ustore[21]  = mk(4'd2, 1'b0, 2'd0, 7'd60,  7'd21);
    ustore[60]  = mk(4'd6, 1'b0, 2'd0, 7'd70,  7'd60);
    ustore[70]  = mk(4'd6, 1'b0, 2'd0, 7'd80,  7'd70);
    ustore[80]  = mk(4'd6, 1'b0, 2'd0, 7'd90,  7'd80);
    ustore[90]  = mk(4'd6, 1'b0, 2'd0, 7'd100, 7'd90);
    ustore[100] = mk(4'd6, 1'b0, 2'd0, 7'd110, 7'd100);
    ustore[110] = mk(4'd7, 1'b0, 2'd0, 7'd0,   7'd110);
    ustore[91]  = mk(4'd7, 1'b0, 2'd0, 7'd0,   7'd91);
    ustore[81]  = mk(4'd7, 1'b0, 2'd0, 7'd0,   7'd81);
    ustore[71]  = mk(4'd7, 1'b0, 2'd0, 7'd0,   7'd71);
    ustore[61]  = mk(4'd7, 1'b0, 2'd0, 7'd0,   7'd61);
    ustore[127] = mk(4'd3, 1'b0, 2'd0, 7'd0,   7'd127);
    ustore[3]   = mk(4'd12, 1'b0, 2'd0, 7'd0,  7'd3);
    ustore[4]   = mk(4'd2, 1'b0, 2'd0, 7'd4,   7'd4);

    // Held in reset
    step();
    step();
    check("rst_addr", 32'(ustore_addr), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_state", 32'(curr_state), 32'd0);
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Boot cycle: word0 is JUMP 5 but address is forced to 0
    reset = 1'b1;
    #1;
    check("boot_addr", 32'(ustore_addr), 32'd0);
    check("boot_ctrl", 32'(ctrl), 32'd0);
    step();
    check("e1_state", 32'(curr_state), 32'd0);
    check("e1_addr", 32'(ustore_addr), 32'd5);
    check("e1_ctrl", 32'(ctrl), 32'h12340);
    step();
    check("e2_state", 32'(curr_state), 32'd5);
    check("e2_ctrl", 32'(ctrl), 32'h1234F);

    // WAIT at 8 on cond[0]
    for (int k = 0; k < 4; k++) begin
      step();
      check("wait_hold", 32'(curr_state), 32'd8);
      check("wait_addr", 32'(ustore_addr), 32'd8);
    end
    cond[0] = 1'b1;
    #1;
    check("wait_release_addr", 32'(ustore_addr), 32'd9);
    step();
    check("wait_exit", 32'(curr_state), 32'd9);

    // BRANCH at 10, inverted cond[1]
    step();
    check("br_at", 32'(curr_state), 32'd10);
    check("br_taken_addr", 32'(ustore_addr), 32'd40);
    step();
    check("br_taken", 32'(curr_state), 32'd40);
    cond[1] = 1'b1;
    step();
    check("br_at2", 32'(curr_state), 32'd10);
    check("br_fall_addr", 32'(ustore_addr), 32'd11);
    step();
    check("br_fall", 32'(curr_state), 32'd11);

    // CALL 50 at 20, RETURN at 50
    step();
    check("call_at", 32'(curr_state), 32'd20);
    check("call_sp0", 32'(sp), 32'd0);
    step();
    check("call_tgt", 32'(curr_state), 32'd50);
    check("call_sp1", 32'(sp), 32'd1);
    check("ret_addr", 32'(ustore_addr), 32'd21);
    step();
    check("ret_land", 32'(curr_state), 32'd21);
    check("ret_sp0", 32'(sp), 32'd0);
    check("ret_err", 32'(err), 32'd0);

    // Five nested calls into a 4-deep stack
    step();
    check("nest_60", 32'(curr_state), 32'd60);
    step();
    check("nest_70", 32'(curr_state), 32'd70);
    check("nest_sp1", 32'(sp), 32'd1);
    step();
    step();
    check("nest_90", 32'(curr_state), 32'd90);
    check("nest_sp3", 32'(sp), 32'd3);
    step();
    check("nest_100", 32'(curr_state), 32'd100);
    check("nest_sp4", 32'(sp), 32'd4);
    check("nest_err0", 32'(err), 32'd0);
    step();
    check("ovf_land", 32'(curr_state), 32'd110);
    check("ovf_sp", 32'(sp), 32'd4);
    check("ovf_err", 32'(err), 32'd1);

    // Five returns; the fifth underflows to the fetch entry
    step();
    check("pop_91", 32'(curr_state), 32'd91);
    check("pop_sp3", 32'(sp), 32'd3);
    step();
    check("pop_81", 32'(curr_state), 32'd81);
    step();
    check("pop_71", 32'(curr_state), 32'd71);
    step();
    check("pop_61", 32'(curr_state), 32'd61);
    check("pop_sp0", 32'(sp), 32'd0);
    check("udf_addr", 32'(ustore_addr), 32'd1);
    step();
    check("udf_land", 32'(curr_state), 32'd1);
    check("udf_sp", 32'(sp), 32'd0);
    check("udf_err", 32'(err), 32'd1);

    // Asynchronous reset mid-program
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", 32'(curr_state), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_ctrl", 32'(ctrl), 32'd0);
    check("arst_addr", 32'(ustore_addr), 32'd0);

    // Restart through DISPATCH: 0 -> 127 -> wrap to 0 -> 3 (op 12) -> 4
    ustore[0] = mk(4'd0, 1'b0, 2'd0, 7'd0, 7'd0);
    dispatch_addr = 7'd127;
    step();
    reset = 1'b1;
    #1;
    check("reboot_addr", 32'(ustore_addr), 32'd0);
    step();
    check("disp_state", 32'(curr_state), 32'd0);
    check("disp_addr", 32'(ustore_addr), 32'd127);
    step();
    check("wrap_state", 32'(curr_state), 32'd127);
    check("wrap_addr", 32'(ustore_addr), 32'd0);
    dispatch_addr = 7'd3;
    step();
    check("disp2_addr", 32'(ustore_addr), 32'd3);
    step();
    check("ill_state", 32'(curr_state), 32'd3);
    check("ill_addr", 32'(ustore_addr), 32'd4);
    check("ill_err_pre", 32'(err), 32'd0);
    step();
    check("ill_next", 32'(curr_state), 32'd4);
    check("ill_err", 32'(err), 32'd1);
    step();
    check("err_sticky", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
